program_loader: RTL

Boot-time controller that fills the 16-word program RAM from an external byte stream before the CPU runs. It sits beside the microcode controller and owns the shared 8-bit bus while loading. It drives the MAR-load and RAM-write strobes, feeds the address and data bytes onto the bus through a tri8, and holds the CPU in clear. When the last word is written it releases the CPU, which starts executing from address 0.

---
 rtl/program_loader_pkg.sv | 16 +
 rtl/program_loader_if.sv | 33 +++
 rtl/program_loader.sv | 80 ++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// Shared constants for the boot-time program loader: state encoding,
// default geometry and bus width.
package program_loader_pkg;

    localparam int DEPTH_DEF  = 16;
    localparam int ADDR_W_DEF = 4;
    localparam int BUS_W      = 8;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HOLD = 3'd1;
    localparam logic [2:0] S_ADDR = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_DATA = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

endpackage

// File: rtl/program_loader_if.sv
// Host byte stream, bus drive and CPU-control strobes of the program loader.
interface program_loader_if
    import program_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) ();

    logic              start;
    logic [BUS_W-1:0]  byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic [BUS_W-1:0]  bus_out;
    logic              bus_drive;
    logic              MI;
    logic              RI;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] load_addr;

    modport master (
        input  start, byte_in, byte_valid,
        output byte_ready, bus_out, bus_drive, MI, RI,
        output cpu_hold, busy, done, load_addr
    );

    modport slave (
        output start, byte_in, byte_valid,
        input  byte_ready, bus_out, bus_drive, MI, RI,
        input  cpu_hold, busy, done, load_addr
    );

endinterface

// File: rtl/program_loader.sv
// Fills program RAM from a host byte stream: per word it loads MAR with the
// address, waits for one byte, then writes it, holding the CPU in clear throughout.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    program_loader_if.master lif
);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [BUS_W-1:0]  data_q,  data_d;
    logic              last_word;

    assign last_word = (addr_q == ADDR_W'(DEPTH - 1));

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: if (lif.start) begin
                state_d = S_HOLD;
                addr_d  = '0;
            end
            S_HOLD: state_d = S_ADDR;
            S_ADDR: state_d = S_WAIT;
            // byte_ready is high throughout WAIT, so valid alone completes the handshake.
            S_WAIT: if (lif.byte_valid) begin
                data_d  = lif.byte_in;
                state_d = S_DATA;
            end
            S_DATA: begin
                if (last_word) begin
                    state_d = S_DONE;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = S_ADDR;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                addr_d  = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // All outputs are pure decodes of registered state.
    assign lif.byte_ready = (state_q == S_WAIT);
    assign lif.MI         = (state_q == S_ADDR);
    assign lif.RI         = (state_q == S_DATA);
    assign lif.bus_drive  = lif.MI | lif.RI;
    assign lif.bus_out    = (state_q == S_ADDR) ? BUS_W'(addr_q) :
                            (state_q == S_DATA) ? data_q : '0;
    assign lif.busy       = (state_q == S_HOLD) || (state_q == S_ADDR) || (state_q == S_WAIT) ||
                            (state_q == S_DATA) || (state_q == S_DONE);
    assign lif.cpu_hold   = lif.busy;
    assign lif.done       = (state_q == S_DONE);
    assign lif.load_addr  = addr_q;

endmodule
